bin_to_7seg_scanner: RTL and testbench
======================================

// Module: bin_to_7seg_scanner
// PURPOSE
//  Parametrised binary-to-decimal display engine for the calculator boards.
//  - Iterative (shift-add-3) binary->BCD conversion, one bit per clock.
//  - Holds the converted value and time-multiplexes it onto DIGITS common-anode 7-seg digits.
//  - Adds an overflow indication and a load/busy/valid handshake.
//  - Replaces the fixed divide/modulo BCD split and fixed 4-digit mux in calculator top levels.
// PARAMETERS
//  WIDTH        8      binary input width (>=1)
//  DIGITS       4      number of display digits (>=1)
//  REFRESH_DIV  25000  clk cycles each digit is held active (>=1)
// PORTS
//  clk     in   1              system clock
//  rst     in   1              synchronous active-high reset
//  load    in   1              start conversion of bin (sampled in IDLE only)
//  bin     in   WIDTH          unsigned value to display
//  busy    out  1              conversion in progress
//  valid   out  1              display holds the result of the last accepted load
//  ovf     out  1              last result needs more than DIGITS decimal digits
//  LEDSEL  out  DIGITS         digit enables, active-low, one-hot-zero
//  LEDOUT  out  8              segments {dp,g,f,e,d,c,b,a}, active-low, dp always 1
// BEHAVIOUR
//  - Reset values: busy=0, valid=0, ovf=0, display register=0, LEDSEL=~1 (digit 0), LEDOUT=8'hC0.
//  - Internal BCD scratch: NB=max(DIGITS,(WIDTH+2)/3) digits.
//  - FSM states: IDLE, CONV, COMMIT.
//    IDLE: load=1 -> latch bin, clear scratch, bit counter=WIDTH, busy<=1, valid<=0, go to CONV.
//    CONV: each cycle, add 3 to every scratch digit >=5, then shift {scratch,bin_sh} left 1;
//          decrement counter; after WIDTH CONV cycles go to COMMIT.
//    COMMIT: copy low DIGITS digits to display register; ovf<=|(digits DIGITS..NB-1);
//            busy<=0, valid<=1, go to IDLE.
//  - Latency: display, valid and ovf update on the (WIDTH+1)th edge after the edge sampling load.
//  - Handshake:
//    - load while busy is ignored; the captured bin is not re-sampled during conversion.
//    - valid stays high until the next accepted load.
//    - The display keeps the old value until COMMIT, so there is no partial update.
//  - Scan:
//    - Prescaler counts 0..REFRESH_DIV-1.
//    - At terminal count, digit index increments and wraps DIGITS-1 -> 0.
//    - LEDSEL = ~(1<<index).
//  - Decode: 0..9 -> C0,F9,A4,B0,99,92,82,F8,80,90 (hex); codes 10..15 -> FF (blank).
//  - ovf=1: every digit shows dash (8'hBF) regardless of the stored value.
//  - Scan runs continuously and independently of conversion; load during scan has no scan effect.
//  - rst mid-conversion: abort to IDLE; all outputs return to reset values on that edge.
//  - bin=0 -> all digits 0 (see CONFIGURATION). Max input 2^WIDTH-1 converts without error.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined:
//    - Digits above the most significant nonzero digit output 8'hFF.
//    - Digit 0 is never blanked; value 0 shows a single "0".
//    - Blanking is not applied when ovf=1.
//  LEAD_ZERO_BLANK_EN undefined: all DIGITS digits are always shown, leading zeros included.
// TESTING (WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless noted)
//  1 rst=1 one cycle -> busy=0, valid=0, ovf=0, LEDSEL=4'b1110, LEDOUT=8'hC0.
//  2 load=1, bin=255 -> busy high 9 cycles; valid=1 on 9th edge;
//    digit0..3 = 92,92,A4,C0 (C0 -> FF with LEAD_ZERO_BLANK_EN).
//  3 load bin=255, then load=1 bin=7 three cycles later -> second load ignored, result 255;
//    next load bin=7 after valid -> digit0=F8.
//  4 No load, 20 cycles -> LEDSEL 1110,1101,1011,0111,1110, each held exactly 4 cycles.
//  5 DIGITS=2, load bin=100 -> ovf=1, both digits 8'hBF;
//    then load bin=99 -> ovf=0, both digits 8'h90.
//  6 load bin=200, rst=1 on 4th CONV cycle -> busy=0, valid=0, display 0;
//    LEAD_ZERO_BLANK_EN, bin=0 -> digits3..1=FF, digit0=C0.

Source files
------------

// File: rtl/bin_to_7seg_scanner.sv
// bin_to_7seg_scanner
//   Converts an unsigned binary value to decimal with a shift-add-3 engine
//   (one bit per clock), keeps the result in a display register and
//   time-multiplexes it onto DIGITS common-anode seven-segment digits.
//
// Optional feature macro: LEAD_ZERO_BLANK_EN
//   defined   -> digits above the most significant nonzero digit are blanked
//                (digit 0 always shown, no blanking while ovf=1)
//   undefined -> every digit is shown, leading zeros included
//
// Parameters
//   WIDTH        binary input width (>=1)
//   DIGITS       number of display digits (>=1)
//   REFRESH_DIV  clk cycles each digit stays active (>=1)
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   load    in   start conversion of bin (only honoured while idle)
//   bin     in   [WIDTH-1:0] unsigned value to display
//   busy    out  conversion in progress
//   valid   out  display holds the result of the last accepted load
//   ovf     out  last result needs more than DIGITS decimal digits
//   LEDSEL  out  [DIGITS-1:0] digit enables, active-low, one-hot-zero
//   LEDOUT  out  [7:0] segments {dp,g,f,e,d,c,b,a}, active-low, dp always 1
module bin_to_7seg_scanner #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 25000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  bin,
   output logic              busy,
   output logic              valid,
   output logic              ovf,
   output logic [DIGITS-1:0] LEDSEL,
   output logic [7:0]        LEDOUT
);

   // Scratch must hold every decimal digit of 2^WIDTH-1 so overflow is visible.
   localparam int NB = (DIGITS > (WIDTH + 2) / 3) ? DIGITS : (WIDTH + 2) / 3;
   localparam int SW = NB * 4;
   localparam int DW = DIGITS * 4;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    bin_sh_q, bin_sh_d;
   logic [SW-1:0]       scratch_q, scratch_d;
   logic [DW-1:0]       display_q, display_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DIGITS-1:0]   ledsel_q, ledsel_d;
   logic [7:0]          ledout_q, ledout_d;

   logic [SW-1:0]       adj_s;
   logic                upper_nz_s;
   logic [3:0]          digit_s;
   logic                blank_s;

   // Active-low segment pattern for one BCD code; non-decimal codes blank.
   function automatic logic [7:0] seg7(input logic [3:0] code);
      case (code)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   // Digits beyond the display width only exist when the scratch is wider.
   generate
      if (NB > DIGITS) begin : g_ovf
         assign upper_nz_s = |scratch_q[SW-1:DW];
      end else begin : g_no_ovf
         assign upper_nz_s = 1'b0;
      end
   endgenerate

   // Add-3 correction applied to every scratch digit before the shift.
   always_comb begin
      adj_s = scratch_q;
      for (int k = 0; k < NB; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            adj_s[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end else begin
            adj_s[4*k +: 4] = scratch_q[4*k +: 4];
         end
      end
   end

   // Conversion FSM: next state, datapath and handshake flags.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bin_sh_d  = bin_sh_q;
      scratch_d = scratch_q;
      display_d = display_q;
      busy_d    = busy_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_sh_d  = bin;
               scratch_d = '0;
               cnt_d     = CNT_INIT;
               busy_d    = 1'b1;
               valid_d   = 1'b0;
               state_d   = S_CONV;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_CONV: begin
            scratch_d = {adj_s[SW-2:0], bin_sh_q[WIDTH-1]};
            bin_sh_d  = bin_sh_q << 1;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_COMMIT;
            end else begin
               state_d = S_CONV;
            end
         end
         S_COMMIT: begin
            // Display changes only here, so a conversion never shows partially.
            display_d = scratch_q[DW-1:0];
            ovf_d     = upper_nz_s;
            busy_d    = 1'b0;
            valid_d   = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
         end
      endcase
   end

   // Digit scan prescaler and index, free-running regardless of conversion.
   always_comb begin
      pre_d = pre_q;
      idx_d = idx_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end
   end

   // Segment/enable outputs are built from next-state values so the
   // registered pins line up with the index they describe.
   always_comb begin
      ledsel_d = ~(DIGITS'(1) << idx_d);
      digit_s  = display_d[int'(idx_d)*4 +: 4];
`ifdef LEAD_ZERO_BLANK_EN
      // Blank when this digit and all above it are zero; digit 0 never blanks.
      if ((idx_d != '0) && ((display_d >> (int'(idx_d) * 4)) == '0)) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
`else
      blank_s  = 1'b0;
`endif
      if (ovf_d) begin
         ledout_d = 8'hBF;
      end else if (blank_s) begin
         ledout_d = 8'hFF;
      end else begin
         ledout_d = seg7(digit_s);
      end
   end

   // All state and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bin_sh_q  <= '0;
         scratch_q <= '0;
         display_q <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         pre_q     <= '0;
         idx_q     <= '0;
         ledsel_q  <= ~DIGITS'(1);
         ledout_q  <= 8'hC0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bin_sh_q  <= bin_sh_d;
         scratch_q <= scratch_d;
         display_q <= display_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         ledsel_q  <= ledsel_d;
         ledout_q  <= ledout_d;
      end
   end

   assign busy   = busy_q;
   assign valid  = valid_q;
   assign ovf    = ovf_q;
   assign LEDSEL = ledsel_q;
   assign LEDOUT = ledout_q;

endmodule

// File: tb/tb_bin_to_7seg_scanner.sv
// Directed bench for bin_to_7seg_scanner. Two instances share clk/rst:
// dut (WIDTH=8, DIGITS=4, REFRESH_DIV=4) and dut2 (DIGITS=2) for overflow.
// Honours LEAD_ZERO_BLANK_EN for the expected leading-digit pattern.
module tb_bin_to_7seg_scanner;

   logic       clk;
   logic       rst;
   logic       load, load2;
   logic [7:0] bin, bin2;
   logic       busy, valid, ovf;
   logic       busy2, valid2, ovf2;
   logic [3:0] ledsel;
   logic [1:0] ledsel2;
   logic [7:0] ledout, ledout2;

   int checks = 0;
   int errors = 0;

`ifdef LEAD_ZERO_BLANK_EN
   localparam logic [7:0] Z_HI = 8'hFF;
`else
   localparam logic [7:0] Z_HI = 8'hC0;
`endif

   bin_to_7seg_scanner #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .load(load), .bin(bin),
      .busy(busy), .valid(valid), .ovf(ovf),
      .LEDSEL(ledsel), .LEDOUT(ledout)
   );

   bin_to_7seg_scanner #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
      .clk(clk), .rst(rst), .load(load2), .bin(bin2),
      .busy(busy2), .valid(valid2), .ovf(ovf2),
      .LEDSEL(ledsel2), .LEDOUT(ledout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int inst);
      int n;
      n = 0;
      while (((inst == 0) ? valid : valid2) !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      assert (n < 40) else begin
         errors++;
         $error("FAIL valid_timeout inst=%0d observed=%0d expected<40", inst, n);
      end
   endtask

   task automatic get_digit(input int inst, input int k, output logic [7:0] seg);
      logic [3:0] t4;
      logic [1:0] t2;
      int n;
      t4 = ~(4'b0001 << k);
      t2 = ~(2'b01 << k);
      n  = 0;
      while (((inst == 0) ? (ledsel !== t4) : (ledsel2 !== t2)) && n < 40) begin
         tick();
         n++;
      end
      checks++;
      assert (n < 40) else begin
         errors++;
         $error("FAIL scan_timeout inst=%0d digit=%0d observed=%0d expected<40", inst, k, n);
      end
      seg = (inst == 0) ? ledout : ledout2;
   endtask

   function automatic int idx_of(input logic [3:0] sel);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         if (sel[i] == 1'b0) r = i;
      end
      return r;
   endfunction

   initial begin
      logic [7:0] seg;
      logic [7:0] e255 [4];
      logic [7:0] e0 [4];
      logic [3:0] exp_sel;
      int idx;

      e255[0] = 8'h92; e255[1] = 8'h92; e255[2] = 8'hA4; e255[3] = Z_HI;
      e0[0]   = 8'hC0; e0[1]   = Z_HI;  e0[2]   = Z_HI;  e0[3]   = Z_HI;

      rst = 1'b1; load = 1'b0; bin = 8'd0; load2 = 1'b0; bin2 = 8'd0;

      // 1: reset values
      tick();
      rst = 1'b0;
      chk("rst_busy",    {31'd0, busy},   32'd0);
      chk("rst_valid",   {31'd0, valid},  32'd0);
      chk("rst_ovf",     {31'd0, ovf},    32'd0);
      chk("rst_ledsel",  {28'd0, ledsel}, 32'hE);
      chk("rst_ledout",  {24'd0, ledout}, 32'hC0);
      chk("rst_ledsel2", {30'd0, ledsel2}, 32'h2);

      // 2: convert 255, busy for 9 cycles, valid on the 9th edge
      load = 1'b1; bin = 8'd255;
      tick();
      load = 1'b0; bin = 8'd0;
      chk("l255_busy0", {31'd0, busy}, 32'd1);
      for (int i = 1; i < 9; i++) begin
         tick();
         chk("l255_busy_mid",  {31'd0, busy},  32'd1);
         chk("l255_valid_mid", {31'd0, valid}, 32'd0);
      end
      tick();
      chk("l255_busy_end",  {31'd0, busy},  32'd0);
      chk("l255_valid_end", {31'd0, valid}, 32'd1);
      chk("l255_ovf",       {31'd0, ovf},   32'd0);
      for (int k = 0; k < 4; k++) begin
         get_digit(0, k, seg);
         chk($sformatf("l255_digit%0d", k), {24'd0, seg}, {24'd0, e255[k]});
      end

      // 3: load during busy is ignored
      load = 1'b1; bin = 8'd255;
      tick();
      load = 1'b0;
      chk("l3_valid_clr", {31'd0, valid}, 32'd0);
      tick(); tick(); tick();
      load = 1'b1; bin = 8'd7;
      tick();
      load = 1'b0; bin = 8'd0;
      wait_valid(0);
      get_digit(0, 0, seg);
      chk("ign_digit0", {24'd0, seg}, 32'h92);
      get_digit(0, 2, seg);
      chk("ign_digit2", {24'd0, seg}, 32'hA4);
      load = 1'b1; bin = 8'd7;
      tick();
      load = 1'b0; bin = 8'd0;
      tick(); tick();
      // display keeps the 255 result while 7 converts
      idx = idx_of(ledsel);
      chk("hold_old", {24'd0, ledout}, {24'd0, e255[idx]});
      wait_valid(0);
      get_digit(0, 0, seg);
      chk("l7_digit0", {24'd0, seg}, 32'hF8);
      get_digit(0, 1, seg);
      chk("l7_digit1", {24'd0, seg}, {24'd0, Z_HI});

      // 4: scan order and hold time, starting on the first cycle of digit 0
      get_digit(0, 3, seg);
      get_digit(0, 0, seg);
      for (int c = 0; c < 20; c++) begin
         exp_sel = ~(4'b0001 << ((c / 4) % 4));
         chk($sformatf("scan_c%0d", c), {28'd0, ledsel}, {28'd0, exp_sel});
         tick();
      end

      // 5: two-digit instance, overflow then in-range
      load2 = 1'b1; bin2 = 8'd100;
      tick();
      load2 = 1'b0;
      wait_valid(1);
      chk("ovf100", {31'd0, ovf2}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         get_digit(1, k, seg);
         chk($sformatf("ovf100_digit%0d", k), {24'd0, seg}, 32'hBF);
      end
      load2 = 1'b1; bin2 = 8'd99;
      tick();
      load2 = 1'b0;
      wait_valid(1);
      chk("ovf99", {31'd0, ovf2}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         get_digit(1, k, seg);
         chk($sformatf("n99_digit%0d", k), {24'd0, seg}, 32'h90);
      end

      // 6: reset on the 4th conversion cycle aborts cleanly
      load = 1'b1; bin = 8'd200;
      tick();
      load = 1'b0; bin = 8'd0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy",   {31'd0, busy},   32'd0);
      chk("abort_valid",  {31'd0, valid},  32'd0);
      chk("abort_ovf",    {31'd0, ovf},    32'd0);
      chk("abort_ledsel", {28'd0, ledsel}, 32'hE);
      chk("abort_ledout", {24'd0, ledout}, 32'hC0);
      for (int i = 0; i < 12; i++) tick();
      chk("abort_no_commit", {31'd0, valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         get_digit(0, k, seg);
         chk($sformatf("abort_digit%0d", k), {24'd0, seg}, {24'd0, e0[k]});
      end

      // explicit zero conversion
      load = 1'b1; bin = 8'd0;
      tick();
      load = 1'b0;
      wait_valid(0);
      for (int k = 0; k < 4; k++) begin
         get_digit(0, k, seg);
         chk($sformatf("zero_digit%0d", k), {24'd0, seg}, {24'd0, e0[k]});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
